// File: rtl/swbox_cfg_pkg.sv
// Shared constants, types and helpers for the switch-box configuration loader.
// Entry word layout: [5:3] source pin index, [2:0] source side.
package swbox_cfg_pkg;

  localparam int NTB        = 5;
  localparam int NLR        = 4;
  localparam int DW         = 6;
  localparam int NENT       = 2 * NTB + 2 * NLR;
  localparam int FRAME_BITS = 108;

  localparam logic [2:0] SIDE_OFF    = 3'd0;
  localparam logic [2:0] SIDE_TOP    = 3'd1;
  localparam logic [2:0] SIDE_RIGHT  = 3'd2;
  localparam logic [2:0] SIDE_BOTTOM = 3'd3;
  localparam logic [2:0] SIDE_LEFT   = 3'd4;

  localparam logic [2:0] NTB_L    = 3'd5;
  localparam logic [2:0] NLR_L    = 3'd4;
  localparam logic [6:0] LAST_BIT = 7'd107;
  localparam logic [4:0] LAST_IDX = 5'd17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } cfg_state_e;

  typedef struct packed {
    logic [2:0] side;
    logic [2:0] idx;
  } pin_home_t;

  // Side and index of the pin that entry k itself drives.
  function automatic pin_home_t entry_home(input logic [4:0] k);
    pin_home_t h;
    if (k < 5'd5) begin
      h.side = SIDE_TOP;
      h.idx  = 3'(k);
    end else if (k < 5'd10) begin
      h.side = SIDE_BOTTOM;
      h.idx  = 3'(k - 5'd5);
    end else if (k < 5'd14) begin
      h.side = SIDE_LEFT;
      h.idx  = 3'(k - 5'd10);
    end else begin
      h.side = SIDE_RIGHT;
      h.idx  = 3'(k - 5'd14);
    end
    return h;
  endfunction

endpackage

// File: rtl/swbox_entry_check.sv
// Combinational legality check and sanitising of one routing entry.
// Illegal entries and side-off entries both come out as an all-zero word.
module swbox_entry_check
  import swbox_cfg_pkg::*;
(
  input  logic [DW-1:0] entry,
  input  logic [4:0]    k,
  output logic          legal,
  output logic [DW-1:0] clean
);

  logic [2:0] side_s;
  logic [2:0] idx_s;
  pin_home_t  home_s;
  logic       range_ok_s;
  logic       self_s;

  assign side_s = entry[2:0];
  assign idx_s  = entry[5:3];
  assign home_s = entry_home(k);

  // Range check per side, self-drive rejection and normalisation.
  always_comb begin
    range_ok_s = 1'b0;
    case (side_s)
      SIDE_OFF:                range_ok_s = 1'b1;
      SIDE_TOP, SIDE_BOTTOM:   range_ok_s = (idx_s < NTB_L);
      SIDE_RIGHT, SIDE_LEFT:   range_ok_s = (idx_s < NLR_L);
      default:                 range_ok_s = 1'b0;
    endcase
    self_s = (side_s == home_s.side) && (idx_s == home_s.idx);
    legal  = range_ok_s && !self_s;
    if (!legal || (side_s == SIDE_OFF)) begin
      clean = {DW{1'b0}};
    end else begin
      clean = entry;
    end
  end

endmodule

// File: rtl/swbox_cfg_loader.sv
// Bit-serial frame loader: shift into shadow, sanitise one entry per cycle,
// then commit the full frame to the active configuration in one cycle.
module swbox_cfg_loader
  import swbox_cfg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic                 cfg_bit_valid,
  input  logic                 cfg_bit_in,
  output logic                 cfg_busy,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic [4:0]           cfg_err_idx,
  output logic [NENT*DW-1:0]   cfg_flat
);

  cfg_state_e            state_r;
  cfg_state_e            state_s;
  logic [FRAME_BITS-1:0] shadow_r;
  logic [FRAME_BITS-1:0] flat_r;
  logic [6:0]            bit_cnt_r;
  logic [4:0]            idx_r;
  logic [4:0]            err_idx_r;
  logic                  err_r;
  logic                  done_r;
  logic                  busy_r;

  logic                  start_ok_s;
  logic                  last_bit_s;
  logic                  check_en_s;
  logic [DW-1:0]         entry_s;
  logic [DW-1:0]         clean_s;
  logic                  legal_s;

  assign entry_s = shadow_r[int'(idx_r) * DW +: DW];

  swbox_entry_check u_check (
    .entry (entry_s),
    .k     (idx_r),
    .legal (legal_s),
    .clean (clean_s)
  );

  // Next-state decode; abort outranks start, and start is only honoured while loading.
  always_comb begin
    state_s    = state_r;
    start_ok_s = 1'b0;
    last_bit_s = 1'b0;
    check_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (cfg_abort) begin
          state_s = IDLE;
        end else if (cfg_start) begin
          state_s    = SHIFT;
          start_ok_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (cfg_abort) begin
          state_s = IDLE;
        end else if (cfg_start) begin
          state_s    = SHIFT;
          start_ok_s = 1'b1;
        end else if (cfg_bit_valid && (bit_cnt_r == LAST_BIT)) begin
          state_s    = CHECK;
          last_bit_s = 1'b1;
        end else begin
          state_s = SHIFT;
        end
      end
      CHECK: begin
        if (cfg_abort) begin
          state_s = IDLE;
        end else begin
          check_en_s = 1'b1;
          state_s    = (idx_r == LAST_IDX) ? COMMIT : CHECK;
        end
      end
      COMMIT:  state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Shadow shifting, per-entry sanitising, error capture and commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r  <= {FRAME_BITS{1'b0}};
      flat_r    <= {FRAME_BITS{1'b0}};
      bit_cnt_r <= 7'd0;
      idx_r     <= 5'd0;
      err_r     <= 1'b0;
      err_idx_r <= 5'd0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      done_r <= (state_r == COMMIT);
      busy_r <= (state_s != IDLE);

      if (start_ok_s) begin
        bit_cnt_r <= 7'd0;
        err_r     <= 1'b0;
        err_idx_r <= 5'd0;
      end else if ((state_r == SHIFT) && !cfg_abort && cfg_bit_valid) begin
        shadow_r  <= {shadow_r[FRAME_BITS-2:0], cfg_bit_in};
        bit_cnt_r <= bit_cnt_r + 7'd1;
      end

      if (last_bit_s) begin
        idx_r <= 5'd0;
      end else if (check_en_s) begin
        idx_r <= idx_r + 5'd1;
      end

      // Only the first illegal entry of a frame records its index.
      if (check_en_s) begin
        shadow_r[int'(idx_r) * DW +: DW] <= clean_s;
        if (!legal_s) begin
          err_r <= 1'b1;
          if (!err_r) begin
            err_idx_r <= idx_r;
          end
        end
      end

      if (state_r == COMMIT) begin
        flat_r <= shadow_r;
      end
    end
  end

  assign cfg_busy    = busy_r;
  assign cfg_done    = done_r;
  assign cfg_err     = err_r;
  assign cfg_err_idx = err_idx_r;
  assign cfg_flat    = flat_r;

endmodule

// File: tb/tb_swbox_cfg_loader.sv
// Directed bench for swbox_cfg_loader with an edge-scheduled reference model.
module tb_swbox_cfg_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_start = 1'b0;
  logic         cfg_abort = 1'b0;
  logic         cfg_bit_valid = 1'b0;
  logic         cfg_bit_in = 1'b0;
  logic         cfg_busy;
  logic         cfg_done;
  logic         cfg_err;
  logic [4:0]   cfg_err_idx;
  logic [107:0] cfg_flat;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  swbox_cfg_loader dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_bit_valid (cfg_bit_valid),
    .cfg_bit_in    (cfg_bit_in),
    .cfg_busy      (cfg_busy),
    .cfg_done      (cfg_done),
    .cfg_err       (cfg_err),
    .cfg_err_idx   (cfg_err_idx),
    .cfg_flat      (cfg_flat)
  );

  // Reference model: expected outputs plus the edge numbers at which they change.
  logic [107:0] m_flat = 108'd0;
  logic [107:0] pend_flat = 108'd0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         m_err = 1'b0;
  logic [4:0]   m_err_idx = 5'd0;
  logic [4:0]   ev_err_idx = 5'd0;
  int           edges = 0;
  int           ev_start = -1;
  int           ev_abort = -1;
  int           ev_err = -1;
  int           ev_commit = -1;

  task automatic chk(input string nm, input logic [107:0] act, input logic [107:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flat = 108'd0; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0; m_err_idx = 5'd0;
    ev_start = -1; ev_abort = -1; ev_err = -1; ev_commit = -1;
  endtask

  // Sanitised frame and first illegal entry, straight from the routing rules.
  task automatic model_frame(input logic [107:0] f, output logic [107:0] o, output int first_bad);
    o = 108'd0;
    first_bad = -1;
    for (int k = 0; k < 18; k++) begin
      logic [5:0] e;
      int side, pidx, hs, hi;
      bit ok;
      e = f[k*6 +: 6];
      side = int'(e[2:0]);
      pidx = int'(e[5:3]);
      if (k < 5) begin hs = 1; hi = k; end
      else if (k < 10) begin hs = 3; hi = k - 5; end
      else if (k < 14) begin hs = 4; hi = k - 10; end
      else begin hs = 2; hi = k - 14; end
      if (side == 0) ok = 1'b1;
      else if (side == 1 || side == 3) ok = (pidx < 5);
      else if (side == 2 || side == 4) ok = (pidx < 4);
      else ok = 1'b0;
      if (side == hs && pidx == hi) ok = 1'b0;
      if (ok && side != 0) o[k*6 +: 6] = e;
      if (!ok && first_bad < 0) first_bad = k;
    end
  endtask

  always @(posedge clk) begin
    edges++;
    if (!rst) begin
      m_done = 1'b0;
      if (edges == ev_start) begin m_busy = 1'b1; m_err = 1'b0; m_err_idx = 5'd0; end
      if (edges == ev_abort) begin m_busy = 1'b0; ev_commit = -1; ev_err = -1; end
      if (edges == ev_err) begin m_err = 1'b1; m_err_idx = ev_err_idx; end
      if (edges == ev_commit) begin m_flat = pend_flat; m_busy = 1'b0; m_done = 1'b1; end
    end
  end

  always @(negedge clk) begin
    chk("flat", cfg_flat, m_flat);
    chk("busy", 108'(cfg_busy), 108'(m_busy));
    chk("done", 108'(cfg_done), 108'(m_done));
    chk("err", 108'(cfg_err), 108'(m_err));
    chk("err_idx", 108'(cfg_err_idx), 108'(m_err_idx));
  end

  function automatic logic [107:0] put(input logic [107:0] f, input int k, input logic [5:0] e);
    logic [107:0] r;
    r = f;
    r[k*6 +: 6] = e;
    return r;
  endfunction

  task automatic send_frame(input logic [107:0] f, input bit gaps);
    logic [107:0] o;
    int fb;
    @(posedge clk); #1;
    cfg_start = 1'b1;
    ev_start = edges + 1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int b = 107; b >= 0; b--) begin
      if (gaps) begin
        cfg_bit_valid = 1'b0;
        cfg_bit_in = ~f[b];
        repeat (2) begin @(posedge clk); #1; end
      end
      cfg_bit_valid = 1'b1;
      cfg_bit_in = f[b];
      @(posedge clk); #1;
    end
    cfg_bit_valid = 1'b0;
    model_frame(f, o, fb);
    pend_flat = o;
    ev_commit = edges + 19;
    if (fb >= 0) begin
      ev_err = edges + 1 + fb;
      ev_err_idx = 5'(fb);
    end else begin
      ev_err = -1;
    end
  endtask

  task automatic wait_commit();
    int got;
    got = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (cfg_done === 1'b1) begin
        got = c;
        break;
      end
    end
    chk("done_latency", 108'(got), 108'd19);
  endtask

  logic [107:0] fa, fb2, fc, fg;

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_flat", cfg_flat, 108'd0);
    chk("rst_busy", 108'(cfg_busy), 108'd0);
    repeat (10) begin @(posedge clk); #1; end
    chk("idle_flat", cfg_flat, 108'd0);
    chk("idle_busy", 108'(cfg_busy), 108'd0);

    // Two legal routes.
    fa = put(put(108'd0, 0, 6'h13), 14, 6'h0C);
    send_frame(fa, 1'b0);
    wait_commit();
    chk("a_e0", 108'(cfg_flat[5:0]), 108'h13);
    chk("a_e14", 108'(cfg_flat[89:84]), 108'h0C);
    chk("a_err", 108'(cfg_err), 108'd0);

    // Out-of-range, bad side and self-drive entries.
    fb2 = put(put(put(put(put(108'd0, 5, 6'h2A), 9, 6'h07), 0, 6'h01), 1, 6'h19), 16, 6'h02);
    send_frame(fb2, 1'b0);
    wait_commit();
    chk("b_err", 108'(cfg_err), 108'd1);
    chk("b_err_idx", 108'(cfg_err_idx), 108'd0);
    chk("b_e0", 108'(cfg_flat[5:0]), 108'd0);
    chk("b_e5", 108'(cfg_flat[35:30]), 108'd0);
    chk("b_e9", 108'(cfg_flat[59:54]), 108'd0);
    chk("b_e1", 108'(cfg_flat[11:6]), 108'h19);
    chk("b_e16", 108'(cfg_flat[101:96]), 108'h02);

    // Gappy load with an off-side entry carrying a stray index.
    fc = put(fa, 3, 6'h38);
    send_frame(fc, 1'b1);
    wait_commit();
    chk("c_flat", cfg_flat, fa);
    chk("c_err", 108'(cfg_err), 108'd0);

    // Abort partway through a second frame.
    fg = put(fa, 7, 6'h0A);
    @(posedge clk); #1;
    cfg_start = 1'b1;
    ev_start = edges + 1;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    for (int b = 107; b >= 58; b--) begin
      cfg_bit_valid = 1'b1;
      cfg_bit_in = fg[b];
      @(posedge clk); #1;
    end
    cfg_bit_valid = 1'b0;
    cfg_abort = 1'b1;
    ev_abort = edges + 1;
    @(posedge clk); #1;
    cfg_abort = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("abort_busy", 108'(cfg_busy), 108'd0);
    chk("abort_flat", cfg_flat, fa);

    // Reset while checking entry 7, then a clean reload.
    send_frame(fg, 1'b0);
    repeat (7) begin @(posedge clk); #1; end
    chk("pre_rst_busy", 108'(cfg_busy), 108'd1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_flat", cfg_flat, 108'd0);
    chk("mid_rst_busy", 108'(cfg_busy), 108'd0);
    chk("mid_rst_done", 108'(cfg_done), 108'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send_frame(fg, 1'b0);
    wait_commit();
    chk("reload_flat", cfg_flat, fg);
    chk("reload_e7", 108'(cfg_flat[47:42]), 108'h0A);

    repeat (3) begin @(posedge clk); #1; end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/swbox_cfg_loader.md
Name: swbox_cfg_loader

Overview:
Bit-serial configuration loader for one switch-box matrix (5 top/bottom pins, 4 left/right pins, 18 six-bit routing entries).
- Shifts a full configuration frame into a shadow register.
- Validates and sanitises each entry, one per cycle.
- Commits the whole frame to the active configuration in a single cycle, so the matrix never sees a partial setup.
- Sits between the device configuration port and the matrix configuration inputs.

Parameters:
NTB, 5, pins per top/bottom side
NLR, 4, pins per left/right side
DW, 6, entry width: [5:3] source index, [2:0] source side
NENT, 18, entry count = 2*NTB + 2*NLR

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
cfg_start  in  1  pulse: begin (or restart) frame load
cfg_abort  in  1  pulse: discard load, return to IDLE
cfg_bit_valid  in  1  cfg_bit_in is valid this cycle
cfg_bit_in  in  1  serial config bit
cfg_busy  out  1  state != IDLE
cfg_done  out  1  one-cycle pulse when the active config is updated
cfg_err  out  1  sticky: at least one entry in the last frame was illegal
cfg_err_idx  out  5  index of the first illegal entry in the last frame
cfg_flat  out  NENT*DW  active config; entry k at [k*DW+DW-1 : k*DW]

Behaviour:
- Entry order: k = 0..4 top[0..4], 5..9 bottom[0..4], 10..13 left[0..3], 14..17 right[0..3].
- Side codes: 0 off (high-Z), 1 top, 2 right, 3 bottom, 4 left.
- Reset (async, immediate): cfg_flat = 0 (all pins high-Z), shadow = 0, state IDLE; cfg_busy, cfg_done, cfg_err, cfg_err_idx = 0.
- Frame: 108 bits. Entry 17 is sent first and entry 0 last, each word MSB first. The shadow shifts left with the new bit at LSB, so entry k lands at shadow[k*6+5 : k*6].
- IDLE: cfg_start -> SHIFT; bit counter = 0; cfg_err and cfg_err_idx cleared. Bits are ignored in IDLE.
- SHIFT: on each cycle with cfg_bit_valid, shift and increment the counter. A gap (valid = 0) holds state. When the 108th bit is captured -> CHECK, idx = 0.
- In SHIFT, cfg_start restarts the load (counter = 0; shadow content is don't-care and is overwritten).
- CHECK: one entry per cycle, idx 0..17. After idx 17 -> COMMIT. CHECK takes exactly 18 cycles.
- An entry is illegal if any of the following holds:
  - side field is 5..7;
  - side is 1 or 3 and index >= NTB;
  - side is 2 or 4 and index >= NLR;
  - side and index equal the entry's own pin (self-drive).
- Side 0 with a nonzero index is legal and is normalised to 6'b000000.
- Illegal entry: the shadow entry is written to 0 and cfg_err is set. cfg_err_idx is loaded only on the first illegal entry of the frame.
- COMMIT (1 cycle): on the edge leaving COMMIT, cfg_flat <= shadow, cfg_done = 1 for one cycle, state -> IDLE.
- Latency: cfg_flat update and cfg_done are visible 19 clock edges after the edge that captured bit 108.
- cfg_abort in SHIFT or CHECK: -> IDLE next edge; cfg_flat unchanged; no cfg_done.
- cfg_abort in COMMIT is ignored (the commit completes).
- cfg_abort has priority over cfg_start in the same cycle.
- cfg_start in CHECK or COMMIT is ignored.
- cfg_flat changes only on COMMIT or reset, never mid-load.
- cfg_err and cfg_err_idx hold until the next cfg_start.

Decomposition:
- Package swbox_cfg_pkg holds:
  - side-code constants SIDE_OFF/TOP/RIGHT/BOTTOM/LEFT;
  - NTB, NLR, DW, NENT, FRAME_BITS = 108;
  - state enum IDLE/SHIFT/CHECK/COMMIT;
  - function entry_home(k) returning the entry's own side and index.
- Sub-module: swbox_entry_check. Purely combinational: inputs entry word and k; outputs legal flag and sanitised word. Instantiated once and time-shared across the CHECK cycles.

Test Plan:
- Reset, then idle 10 cycles -> cfg_flat = 0, cfg_busy = 0, cfg_done never asserted.
- Frame with entry 0 = 6'b010_011 (bottom[2]), entry 14 = 6'b001_100 (left[1]), all others 0 -> cfg_done exactly 19 edges after the last bit; cfg_flat[5:0] = 6'h13; cfg_flat[89:84] = 6'h0C; cfg_err = 0.
- Frame with entry 5 = 6'b101_010 (right[5], out of range), entry 9 = 6'b000_111 (bad side), entry 0 = 6'b000_001 (self-drive top[0]) -> cfg_err = 1, cfg_err_idx = 0; entries 0, 5, 9 committed as 0; other entries intact.
- Valid toggling 1-of-3 cycles across the frame -> result identical to the gap-free load; entry 3 = 6'b111_000 normalised to 0 with cfg_err = 0.
- Good frame committed, then cfg_abort after 50 bits of a second frame -> IDLE, cfg_flat still holds the first frame, no cfg_done.
- Assert rst during CHECK at idx 7 -> cfg_flat = 0 and outputs cleared immediately, no cfg_done. After release, a full reload commits normally.
